// File: rtl/rgb_pwm_peripheral.sv
// Memory-mapped LED/RGB PWM peripheral on the core's data-memory bus.
// Duties are double-buffered and move shadow->active only when the PWM counter wraps.
module rgb_pwm_peripheral #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_hit,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_DUTY_R   = 3'd1;
  localparam logic [2:0] IDX_DUTY_G   = 3'd2;
  localparam logic [2:0] IDX_DUTY_B   = 3'd3;
  localparam logic [2:0] IDX_PRESCALE = 3'd4;
  localparam logic [2:0] IDX_STATUS   = 3'd5;

  logic        hit;
  logic        wr;
  logic        duty_wr;
  logic [2:0]  idx;
  logic        tick;
  logic        wrap;
  logic [31:0] rd_val;

  logic        en_q, en_d;
  logic        led_ctrl_q, led_ctrl_d;
  logic [7:0]  shd_r_q, shd_r_d;
  logic [7:0]  shd_g_q, shd_g_d;
  logic [7:0]  shd_b_q, shd_b_d;
  logic [7:0]  act_r_q, act_r_d;
  logic [7:0]  act_g_q, act_g_d;
  logic [7:0]  act_b_q, act_b_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] psc_q, psc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
  logic        led_q, led_d;
  logic        rgb_r_q, rgb_r_d;
  logic        rgb_g_q, rgb_g_d;
  logic        rgb_b_q, rgb_b_d;

  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  assign hit     = mem_en && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign wr      = hit && mem_we;
  assign idx     = mem_addr[4:2];
  assign duty_wr = wr && ((idx == IDX_DUTY_R) || (idx == IDX_DUTY_G) || (idx == IDX_DUTY_B));

  // Register-file writes
  always_comb begin
    en_d       = en_q;
    led_ctrl_d = led_ctrl_q;
    shd_r_d    = shd_r_q;
    shd_g_d    = shd_g_q;
    shd_b_d    = shd_b_q;
    prescale_d = prescale_q;
    if (wr) begin
      case (idx)
        IDX_CTRL: begin
          en_d       = mem_wdata[0];
          led_ctrl_d = mem_wdata[1];
        end
        IDX_DUTY_R:   shd_r_d    = mem_wdata[7:0];
        IDX_DUTY_G:   shd_g_d    = mem_wdata[7:0];
        IDX_DUTY_B:   shd_b_d    = mem_wdata[7:0];
        IDX_PRESCALE: prescale_d = mem_wdata[15:0];
        default: ;
      endcase
    end
  end

  // Prescaler: a psc left above a freshly lowered PRESCALE rolls through 65535 without a tick
  always_comb begin
    tick  = 1'b0;
    psc_d = psc_q;
    cnt_d = cnt_q;
    if (en_q) begin
      if (psc_q == prescale_q) begin
        tick  = 1'b1;
        psc_d = 16'd0;
      end else begin
        psc_d = psc_q + 16'd1;
      end
    end
    if (tick) cnt_d = cnt_q + 8'd1;
  end

  assign wrap = tick && (cnt_q == 8'hFF);

  // Transfer takes the post-write shadow so a store on the wrap edge lands in active too
  always_comb begin
    act_r_d = act_r_q;
    act_g_d = act_g_q;
    act_b_d = act_b_q;
    pend_d  = pend_q;
    if (wrap) begin
      act_r_d = shd_r_d;
      act_g_d = shd_g_d;
      act_b_d = shd_b_d;
      pend_d  = 1'b0;
    end else if (duty_wr) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    rgb_r_d = (en_q && (cnt_q < act_r_q)) ^ ACTIVE_LOW;
    rgb_g_d = (en_q && (cnt_q < act_g_q)) ^ ACTIVE_LOW;
    rgb_b_d = (en_q && (cnt_q < act_b_q)) ^ ACTIVE_LOW;
    led_d   = led_ctrl_q;
  end

  always_comb begin
    rd_val = 32'd0;
    case (idx)
      IDX_CTRL:     rd_val = {30'd0, led_ctrl_q, en_q};
      IDX_DUTY_R:   rd_val = {24'd0, shd_r_q};
      IDX_DUTY_G:   rd_val = {24'd0, shd_g_q};
      IDX_DUTY_B:   rd_val = {24'd0, shd_b_q};
      IDX_PRESCALE: rd_val = {16'd0, prescale_q};
      IDX_STATUS:   rd_val = {16'd0, cnt_q, 7'd0, pend_q};
      default:      rd_val = 32'd0;
    endcase
    rdata_d = (hit && !mem_we) ? rd_val : 32'd0;
    hit_d   = hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      led_ctrl_q <= 1'b0;
      shd_r_q    <= 8'd0;
      shd_g_q    <= 8'd0;
      shd_b_q    <= 8'd0;
      act_r_q    <= 8'd0;
      act_g_q    <= 8'd0;
      act_b_q    <= 8'd0;
      prescale_q <= PRESCALE_RST;
      psc_q      <= 16'd0;
      cnt_q      <= 8'd0;
      pend_q     <= 1'b0;
      rdata_q    <= 32'd0;
      hit_q      <= 1'b0;
      led_q      <= 1'b0;
      rgb_r_q    <= ACTIVE_LOW;
      rgb_g_q    <= ACTIVE_LOW;
      rgb_b_q    <= ACTIVE_LOW;
    end else begin
      en_q       <= en_d;
      led_ctrl_q <= led_ctrl_d;
      shd_r_q    <= shd_r_d;
      shd_g_q    <= shd_g_d;
      shd_b_q    <= shd_b_d;
      act_r_q    <= act_r_d;
      act_g_q    <= act_g_d;
      act_b_q    <= act_b_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      led_q      <= led_d;
      rgb_r_q    <= rgb_r_d;
      rgb_g_q    <= rgb_g_d;
      rgb_b_q    <= rgb_b_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_hit   = hit_q;
  assign LED       = led_q;
  assign RGB_R     = rgb_r_q;
  assign RGB_G     = rgb_g_q;
  assign RGB_B     = rgb_b_q;

endmodule

// File: tb/tb_rgb_pwm_peripheral.sv
// Directed bench for rgb_pwm_peripheral: bus accesses checked through a scoreboard queue,
// PWM timing checked against cycle positions counted from the enabling store.
module tb_rgb_pwm_peripheral;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_hit;
  logic        LED, RGB_R, RGB_G, RGB_B;

  rgb_pwm_peripheral #(
    .BASE_ADDR(BASE), .ACTIVE_LOW(1'b1), .PRESCALE_RST(16'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_hit(mem_hit), .LED(LED), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        hit;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_hit, input logic [31:0] exp_data, input string tag);
    exp_t e;
    @(negedge clk);
    mem_en = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    e.tag = tag; e.hit = exp_hit; e.data = exp_data; e.chk_data = !we;
    sb.push_back(e);
    @(posedge clk); #1;
    mem_en = 1'b0; mem_we = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hit"}, {31'd0, mem_hit}, {31'd0, e.hit});
      if (e.chk_data) chk({e.tag, "_data"}, mem_rdata, e.data);
    end
  endtask

  task automatic wr(input int idx, input logic [31:0] data, input string tag);
    access(1'b1, BASE + 32'(idx * 4), data, 1'b1, 32'd0, tag);
  endtask

  task automatic rd(input int idx, input logic [31:0] expv, input string tag);
    access(1'b0, BASE + 32'(idx * 4), 32'd0, 1'b1, expv, tag);
  endtask

  // Advance until edge number k has passed; the next access then lands on edge k+1
  task automatic step_to(input int unsigned k);
    while (cyc < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    mem_en = 1'b0; mem_we = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic count_lows(output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    repeat (256) begin
      @(posedge clk); #1;
      if (!RGB_R) nr++;
      if (!RGB_G) ng++;
      if (!RGB_B) nb++;
    end
  endtask

  initial begin
    int unsigned e0;
    int nr, ng, nb;

    // Reset and register readback
    do_reset();
    chk("rst_rgb_r", {31'd0, RGB_R}, 32'd1);
    chk("rst_rgb_g", {31'd0, RGB_G}, 32'd1);
    chk("rst_rgb_b", {31'd0, RGB_B}, 32'd1);
    chk("rst_led", {31'd0, LED}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rd(5, 32'd0, "rst_status");
    wr(2, 32'hFFFF_FFAB, "wr_duty_g");
    wr(4, 32'h0000_1234, "wr_prescale");
    rd(2, 32'h0000_00AB, "rb_duty_g");
    rd(4, 32'h0000_1234, "rb_prescale");
    rd(6, 32'd0, "rb_reserved6");
    access(1'b0, 32'h0000_1000, 32'd0, 1'b0, 32'd0, "miss");
    access(1'b0, BASE + 32'd11, 32'd0, 1'b1, 32'h0000_00AB, "low_bits_ignored");
    wr(5, 32'hFFFF_FFFF, "wr_status");
    rd(5, 32'h0000_0001, "status_pend_after_duty");
    wr(7, 32'hFFFF_FFFF, "wr_reserved7");
    rd(7, 32'd0, "rb_reserved7");
    wr(0, 32'h2, "led_on");
    step_to(cyc + 1);
    chk("led_lit", {31'd0, LED}, 32'd1);
    chk("led_no_rgb", {31'd0, RGB_R}, 32'd1);
    rd(0, 32'h2, "rb_ctrl");

    // PWM duty
    do_reset();
    wr(1, 32'd64, "pwm_r");
    wr(2, 32'd171, "pwm_g");
    wr(3, 32'd255, "pwm_b");
    wr(0, 32'd1, "pwm_en");
    e0 = cyc;
    step_to(e0 + 300);
    count_lows(nr, ng, nb);
    chk("pwm_r64_lows", 32'(nr), 32'd64);
    chk("pwm_g171_lows", 32'(ng), 32'd171);
    chk("pwm_b255_lows", 32'(nb), 32'd255);
    wr(1, 32'd0, "pwm_r0");
    e0 = cyc;
    step_to(e0 + 300);
    count_lows(nr, ng, nb);
    chk("pwm_r0_lows", 32'(nr), 32'd0);
    chk("pwm_g171_again", 32'(ng), 32'd171);

    // Double buffering
    do_reset();
    wr(3, 32'd50, "db_b50");
    wr(0, 32'd1, "db_en");
    e0 = cyc;
    step_to(e0 + 356);
    wr(3, 32'd200, "db_b200");
    rd(5, 32'h0000_6501, "db_status_pend");
    chk("db_old_duty", {31'd0, RGB_B}, 32'd1);
    step_to(e0 + 511);
    rd(5, 32'h0000_FF01, "db_status_pre_wrap");
    rd(5, 32'h0000_0000, "db_status_wrap");
    step_to(e0 + 633);
    chk("db_new_duty", {31'd0, RGB_B}, 32'd0);
    step_to(e0 + 767);
    wr(3, 32'd10, "db_same_edge");
    rd(5, 32'h0000_0000, "db_same_edge_pend");
    step_to(e0 + 789);
    chk("db_same_edge_duty", {31'd0, RGB_B}, 32'd1);

    // Prescaler and enable
    do_reset();
    wr(4, 32'd3, "ps_set");
    wr(1, 32'd255, "ps_r");
    wr(0, 32'd1, "ps_en");
    e0 = cyc;
    step_to(e0 + 4);
    rd(5, 32'h0000_0101, "ps_cnt1_first");
    step_to(e0 + 7);
    rd(5, 32'h0000_0101, "ps_cnt1_last");
    rd(5, 32'h0000_0201, "ps_cnt2");
    step_to(e0 + 1225);
    chk("ps_lit_before_dis", {31'd0, RGB_R}, 32'd0);
    wr(0, 32'd0, "ps_dis");
    step_to(e0 + 1227);
    chk("ps_unlit_after_dis", {31'd0, RGB_R}, 32'd1);
    rd(5, 32'h0000_3200, "ps_hold");
    step_to(e0 + 1240);
    rd(5, 32'h0000_3200, "ps_hold2");
    wr(0, 32'd1, "ps_reen");
    rd(5, 32'h0000_3200, "ps_resume1");
    rd(5, 32'h0000_3200, "ps_resume2");
    rd(5, 32'h0000_3300, "ps_resume3");

    // Asynchronous reset mid-run
    do_reset();
    wr(1, 32'd128, "ar_r");
    wr(0, 32'd1, "ar_en");
    e0 = cyc;
    step_to(e0 + 333);
    chk("ar_lit_before", {31'd0, RGB_R}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rgb_r_unlit", {31'd0, RGB_R}, 32'd1);
    chk("ar_hit_clear", {31'd0, mem_hit}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1, 32'd0, "ar_duty_r");
    rd(5, 32'd0, "ar_status");
    rd(0, 32'd0, "ar_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
